adxl355_reg_bank: RTL

- Register file of the ADXL355 device model. It sits directly downstream of spi_slave in the mems_clk domain.
- It consumes the address/data strobes spi_slave decodes from the SPI frame and returns read bytes through reg_slave_rd_data/reg_slave_rd_valid.
- It holds ID, status, sample-data and control registers. It auto-increments the address for burst access and snapshots acceleration/temperature so a burst read is coherent.

---
 rtl/adxl355_reg_if.sv | 23 ++
 rtl/adxl355_reg_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/adxl355_reg_if.sv
// SPI-slave to register-bank strobe bus: address/data strobes in, read byte back.
interface adxl355_reg_if;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;

  logic          wr_rd;
  logic [AW-1:0] spi_slave_wr_rd_addr;
  logic          spi_addr_valid;
  logic          spi_data_valid;
  logic [DW-1:0] spi_slave_wr_data;
  logic [DW-1:0] reg_slave_rd_data;
  logic          reg_slave_rd_valid;

  modport master (
    output wr_rd, spi_slave_wr_rd_addr, spi_addr_valid, spi_data_valid, spi_slave_wr_data,
    input  reg_slave_rd_data, reg_slave_rd_valid
  );

  modport slave (
    input  wr_rd, spi_slave_wr_rd_addr, spi_addr_valid, spi_data_valid, spi_slave_wr_data,
    output reg_slave_rd_data, reg_slave_rd_valid
  );
endinterface

// File: rtl/adxl355_reg_bank.sv
// ADXL355 register file: ID/status/sample/control registers with burst
// auto-increment and a snapshot of sample data taken at the start of each read.
module adxl355_reg_bank #(
  parameter logic [7:0] PARTID  = 8'hED,
  parameter logic [7:0] REVID   = 8'h01,
  parameter logic [7:0] PWR_RST = 8'h01
) (
  input  logic        mems_clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        sample_valid,
  input  logic [19:0] sample_x,
  input  logic [19:0] sample_y,
  input  logic [19:0] sample_z,
  input  logic [11:0] sample_temp,
  adxl355_reg_if.slave bus
);

  localparam int unsigned AW  = 7;
  localparam int unsigned DW  = 8;
  localparam int unsigned AXW = 20;
  localparam int unsigned TW  = 12;

  localparam logic [AW-1:0] A_STATUS = 7'h04;
  localparam logic [AW-1:0] A_FILTER = 7'h28;
  localparam logic [AW-1:0] A_PWR    = 7'h2D;
  localparam logic [AW-1:0] A_RESET  = 7'h2F;
  localparam logic [DW-1:0] RST_CODE = 8'h52;

  typedef enum logic [1:0] {IDLE, WR, RD_FETCH, RD_HOLD} state_t;

  state_t          state_q, state_d;
  logic            cs_meta, cs_sync;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   rd_data_q, rd_data_d, rd_mux;
  logic            rd_valid_q, rd_valid_d;
  logic            wr_en, snap, rdy_clr, sample_load, soft_rst_q;
  logic [2:0]      power_q;
  logic [6:0]      filter_q;
  logic            data_rdy_q;
  logic [AXW-1:0]  live_x, live_y, live_z, shd_x, shd_y, shd_z;
  logic [TW-1:0]   live_t, shd_t;

  assign sample_load = sample_valid & ~power_q[0];
  assign bus.reg_slave_rd_data  = rd_data_q;
  assign bus.reg_slave_rd_valid = rd_valid_q;

  // cs_n synchroniser; resets to deselected
  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= cs_n;
      cs_sync <= cs_meta;
    end
  end

  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_sync) begin
      state_d = IDLE;
    end else if (bus.spi_addr_valid) begin
      state_d = bus.wr_rd ? RD_FETCH : WR;
    end else begin
      case (state_q)
        RD_FETCH: state_d = RD_HOLD;
        RD_HOLD:  if (bus.spi_data_valid) state_d = RD_FETCH;
        default:  state_d = state_q;
      endcase
    end
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    ptr_d      = ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    wr_en      = 1'b0;
    snap       = 1'b0;
    rdy_clr    = 1'b0;
    if (cs_sync) begin
      rd_data_d  = '0;
      rd_valid_d = 1'b0;
    end else if (bus.spi_addr_valid) begin
      ptr_d      = bus.spi_slave_wr_rd_addr;
      rd_valid_d = 1'b0;
      snap       = bus.wr_rd;
    end else begin
      case (state_q)
        WR: begin
          if (bus.spi_data_valid) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + AW'(1);
          end
        end
        RD_FETCH: begin
          rd_data_d  = rd_mux;
          rd_valid_d = 1'b1;
          rdy_clr    = (ptr_q == A_STATUS);
        end
        RD_HOLD: begin
          if (bus.spi_data_valid) begin
            rd_valid_d = 1'b0;
            ptr_d      = ptr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      soft_rst_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      soft_rst_q <= wr_en && (ptr_q == A_RESET) && (bus.spi_slave_wr_data == RST_CODE);
    end
  end

  // Sample-data registers 0x06-0x10 come from the read snapshot
  always_comb begin
    case (ptr_q)
      7'h00:   rd_mux = 8'hAD;
      7'h01:   rd_mux = 8'h1D;
      7'h02:   rd_mux = PARTID;
      7'h03:   rd_mux = REVID;
      7'h04:   rd_mux = {7'b0, data_rdy_q};
      7'h06:   rd_mux = {4'b0, shd_t[11:8]};
      7'h07:   rd_mux = shd_t[7:0];
      7'h08:   rd_mux = shd_x[19:12];
      7'h09:   rd_mux = shd_x[11:4];
      7'h0A:   rd_mux = {shd_x[3:0], 4'b0};
      7'h0B:   rd_mux = shd_y[19:12];
      7'h0C:   rd_mux = shd_y[11:4];
      7'h0D:   rd_mux = {shd_y[3:0], 4'b0};
      7'h0E:   rd_mux = shd_z[19:12];
      7'h0F:   rd_mux = shd_z[11:4];
      7'h10:   rd_mux = {shd_z[3:0], 4'b0};
      A_FILTER: rd_mux = {1'b0, filter_q};
      A_PWR:   rd_mux = {5'b0, power_q};
      default: rd_mux = '0;
    endcase
  end

  // Control, status and sample registers; soft reset restores them all
  always_ff @(posedge mems_clk or negedge rst_n) begin
    if (!rst_n) begin
      power_q    <= PWR_RST[2:0];
      filter_q   <= '0;
      data_rdy_q <= 1'b0;
      live_x <= '0; live_y <= '0; live_z <= '0; live_t <= '0;
      shd_x  <= '0; shd_y  <= '0; shd_z  <= '0; shd_t  <= '0;
    end else if (soft_rst_q) begin
      power_q    <= PWR_RST[2:0];
      filter_q   <= '0;
      data_rdy_q <= 1'b0;
      live_x <= '0; live_y <= '0; live_z <= '0; live_t <= '0;
      shd_x  <= '0; shd_y  <= '0; shd_z  <= '0; shd_t  <= '0;
    end else begin
      if (wr_en && (ptr_q == A_FILTER)) filter_q <= bus.spi_slave_wr_data[6:0];
      if (wr_en && (ptr_q == A_PWR))    power_q  <= bus.spi_slave_wr_data[2:0];
      if (sample_load) begin
        live_x <= sample_x;
        live_y <= sample_y;
        live_z <= sample_z;
        live_t <= sample_temp;
      end
      if (sample_load)  data_rdy_q <= 1'b1;
      else if (rdy_clr) data_rdy_q <= 1'b0;
      if (snap) begin
        shd_x <= live_x;
        shd_y <= live_y;
        shd_z <= live_z;
        shd_t <= live_t;
      end
    end
  end

endmodule
